mealy_state_seq: RTL and testbench



---
 rtl/mealy_state_seq.sv | 111 +++++++++++
 tb/tb_mealy_state_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mealy_state_seq.sv
// Registered state/input-hold sequencer feeding the 4-state Mealy output decoder.
// Optional dwell timeout (forced return to A) is built when MEALY_DWELL_TIMEOUT_EN is defined.
module mealy_state_seq #(
    parameter int CNT_W     = 8,
    parameter int DWELL_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic [1:0]       state,
    output logic             in_hold,
    output logic [CNT_W-1:0] trans_count,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_A = 2'b00,
        ST_B = 2'b01,
        ST_C = 2'b10,
        ST_D = 2'b11
    } state_t;

    // Reject out-of-range configuration at elaboration time.
    if (CNT_W < 1 || DWELL_MAX < 1 || DWELL_MAX > 255) begin : g_bad_param
        $error("mealy_state_seq: CNT_W must be >= 1 and DWELL_MAX in 1..255");
    end

    state_t           state_q, state_d, step_nxt;
    logic             in_hold_q, in_hold_d;
    logic [CNT_W-1:0] trans_count_q, trans_count_d;

`ifdef MEALY_DWELL_TIMEOUT_EN
    localparam logic [7:0] DWELL_LIM = 8'(DWELL_MAX);
    logic [7:0] dwell_q, dwell_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        step_nxt = ST_A;
        case (state_q)
            ST_A: step_nxt = in_bit ? ST_C : ST_B;
            ST_B: step_nxt = in_bit ? ST_A : ST_D;
            ST_C: step_nxt = in_bit ? ST_D : ST_C;
            ST_D: step_nxt = in_bit ? ST_B : ST_A;
            default: step_nxt = ST_A;
        endcase
    end

    // An accepted step always wins over a dwell expiry in the same cycle.
    always_comb begin
        state_d       = state_q;
        in_hold_d     = in_hold_q;
        trans_count_d = trans_count_q;
`ifdef MEALY_DWELL_TIMEOUT_EN
        dwell_d       = 8'd0;
        timeout_d     = 1'b0;
`endif
        if (in_valid) begin
            state_d   = step_nxt;
            in_hold_d = in_bit;
            if (step_nxt != state_q) begin
                trans_count_d = trans_count_q + CNT_W'(1);
            end
        end
`ifdef MEALY_DWELL_TIMEOUT_EN
        else if (state_q != ST_A) begin
            if (dwell_q == DWELL_LIM) begin
                state_d   = ST_A;
                in_hold_d = 1'b0;
                timeout_d = 1'b1;
            end else begin
                dwell_d = dwell_q + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_A;
            in_hold_q     <= 1'b0;
            trans_count_q <= '0;
        end else begin
            state_q       <= state_d;
            in_hold_q     <= in_hold_d;
            trans_count_q <= trans_count_d;
        end
    end

`ifdef MEALY_DWELL_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_q   <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            dwell_q   <= dwell_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign state       = state_q;
    assign in_hold     = in_hold_q;
    assign trans_count = trans_count_q;

endmodule

// File: tb/tb_mealy_state_seq.sv
// Self-checking bench for mealy_state_seq: directed scenarios followed by random traffic,
// compared every cycle against a table-driven reference model.
module tb_mealy_state_seq;

    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic [1:0] state, w_state;
    logic       in_hold, w_in_hold;
    logic [7:0] trans_count;
    logic [1:0] w_trans_count;
    logic       timeout, w_timeout;

    int compared = 0;
    int mismatched = 0;

`ifdef MEALY_DWELL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    mealy_state_seq #(.CNT_W(8), .DWELL_MAX(DW)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .state(state), .in_hold(in_hold), .trans_count(trans_count), .timeout(timeout)
    );

    mealy_state_seq #(.CNT_W(2), .DWELL_MAX(DW)) u_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .state(w_state), .in_hold(w_in_hold), .trans_count(w_trans_count), .timeout(w_timeout)
    );

    always #5 clk = ~clk;

    // Reference model: next state looked up by (state*2 + bit); A=0 B=1 C=2 D=3.
    int nxt_tbl [8] = '{1, 2, 3, 0, 2, 3, 0, 1};
    int m_state, m_hold, m_count, m_idle, m_to;

    task automatic model_reset();
        m_state = 0; m_hold = 0; m_count = 0; m_idle = 0; m_to = 0;
    endtask

    task automatic model_step(input bit v, input bit b);
        int n;
        m_to = 0;
        if (v) begin
            n = nxt_tbl[m_state * 2 + int'(b)];
            if (n != m_state) m_count++;
            m_state = n;
            m_hold  = int'(b);
            m_idle  = 0;
        end else if (TO_EN && m_state != 0) begin
            if (m_idle == DW) begin
                m_state = 0; m_hold = 0; m_idle = 0; m_to = 1;
            end else begin
                m_idle++;
            end
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},    32'(state),         32'(m_state));
        chk({tag, ".in_hold"},  32'(in_hold),       32'(m_hold));
        chk({tag, ".count"},    32'(trans_count),   32'(m_count % 256));
        chk({tag, ".timeout"},  32'(timeout),       32'(m_to));
        chk({tag, ".w_count"},  32'(w_trans_count), 32'(m_count % 4));
        chk({tag, ".w_state"},  32'(w_state),       32'(m_state));
        chk({tag, ".w_timeout"}, 32'(w_timeout),    32'(m_to));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled at the same point.
    task automatic cyc(input bit v, input bit b, input string tag);
        in_valid = v;
        in_bit   = b;
        model_step(v, b);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("por");
        @(posedge clk);
        #1;
        check_all("por_held");
        reset = 1'b0;

        // Reach D with count 2, then reset between edges.
        cyc(1'b1, 1'b0, "to_b");
        cyc(1'b1, 1'b0, "to_d");
        chk("pre_reset_state", 32'(state), 32'd3);
        chk("pre_reset_count", 32'(trans_count), 32'd2);
        pulse_reset("mid_reset");

        // Full walk 0,0,0,1,1 from A: B,D,A,C,D.
        cyc(1'b1, 1'b0, "walk0");
        cyc(1'b1, 1'b0, "walk1");
        cyc(1'b1, 1'b0, "walk2");
        cyc(1'b1, 1'b1, "walk3");
        cyc(1'b1, 1'b1, "walk4");
        chk("walk_state", 32'(state), 32'd3);
        chk("walk_count", 32'(trans_count), 32'd5);
        chk("wrap_count", 32'(w_trans_count), 32'd1);

        // D,1 -> B; B,1 -> A; A,1 -> C; then self-loop C,0 and 3 idles.
        cyc(1'b1, 1'b1, "d_to_b");
        cyc(1'b1, 1'b1, "b_to_a");
        cyc(1'b1, 1'b1, "a_to_c");
        cyc(1'b1, 1'b0, "self_loop");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, "idle_c");
        chk("self_loop_state", 32'(state), 32'd2);
        chk("self_loop_count", 32'(trans_count), 32'd8);

        // C -> D -> A -> B, then idle for 5 edges.
        cyc(1'b1, 1'b1, "c_to_d");
        cyc(1'b1, 1'b0, "d_to_a");
        cyc(1'b1, 1'b0, "a_to_b");
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, "dwell");
        chk("to_state", 32'(state), TO_EN ? 32'd0 : 32'd1);
        chk("to_pulse", 32'(timeout), TO_EN ? 32'd1 : 32'd0);
        chk("to_count", 32'(trans_count), 32'd11);
        cyc(1'b0, 1'b0, "after_to");
        chk("to_one_cycle", 32'(timeout), 32'd0);

        // Collision: from B, 4 idles bring dwell to the limit, then a valid step B,1 -> A.
        if (state == 2'd0) cyc(1'b1, 1'b0, "enter_b");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, "pre_coll");
        chk("coll_pre_state", 32'(state), 32'd1);
        cyc(1'b1, 1'b1, "collision");
        chk("coll_state", 32'(state), 32'd0);
        chk("coll_timeout", 32'(timeout), 32'd0);

        // Random traffic with occasional mid-run resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) pulse_reset("rnd_reset");
            cyc($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
